// File: rtl/layer_sequencer_if.sv
// Command/handshake bundle between the instruction decoder and the layer sequencer.
// The decoder side drives the layer configuration and stream status; the sequencer drives the datapath strobes.
interface layer_sequencer_if #(
  parameter int MAC_NUM = 256,
  parameter int CH_W    = 12,
  parameter int DIM_W   = 9
);
  logic               start;
  logic               abort;
  logic [2:0]         kernel_size;
  logic [1:0]         stride;
  logic [DIM_W-1:0]   ofmaps_width;
  logic [DIM_W-1:0]   ofmaps_height;
  logic [CH_W-1:0]    ofmaps_channel;
  logic [CH_W-1:0]    input_channel_size;
  logic               ifmaps_fifo_empty;
  logic               weight_from_bram_valid;

  logic               load_ifmaps;
  logic               address_reset;
  logic               load_weight_preload;
  logic               bram_row_inc;
  logic               load_weight;
  logic [MAC_NUM-1:0] MAC_enable;
  logic               busy;
  logic               layer_finish;
  logic               cfg_error;
  logic [DIM_W-1:0]   out_x;
  logic [DIM_W-1:0]   out_y;

  modport master (
    output start, abort, kernel_size, stride, ofmaps_width, ofmaps_height,
           ofmaps_channel, input_channel_size, ifmaps_fifo_empty, weight_from_bram_valid,
    input  load_ifmaps, address_reset, load_weight_preload, bram_row_inc, load_weight,
           MAC_enable, busy, layer_finish, cfg_error, out_x, out_y
  );

  modport slave (
    input  start, abort, kernel_size, stride, ofmaps_width, ofmaps_height,
           ofmaps_channel, input_channel_size, ifmaps_fifo_empty, weight_from_bram_valid,
    output load_ifmaps, address_reset, load_weight_preload, bram_row_inc, load_weight,
           MAC_enable, busy, layer_finish, cfg_error, out_x, out_y
  );
endinterface

// File: rtl/layer_sequencer.sv
// Convolution layer sequencer: an ifmap FSM walks the output pixels and refills the column window,
// while a weight FSM streams K rows per filter for all F filters of each pixel.
module layer_sequencer #(
  parameter int MAC_NUM = 256,
  parameter int KMAX    = 7,
  parameter int CH_W    = 12,
  parameter int DIM_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  layer_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(KMAX + 1);

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, COMPUTE, DONE} if_state_e;
  typedef enum logic [1:0] {W_IDLE, W_RESET, W_ROW, W_LOAD} w_state_e;

  if_state_e        if_state_q, if_state_d;
  w_state_e         w_state_q, w_state_d;
  logic [CNT_W-1:0] k_q, k_d, need_q, need_d, col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
  logic [1:0]       stride_q, stride_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d, out_x_q, out_x_d, out_y_q, out_y_d;
  logic [CH_W-1:0]  f_q, f_d, ch_q, ch_d, filter_cnt_q, filter_cnt_d;
  logic             cfg_error_q, cfg_error_d;
  logic             cfg_ok, filter_done, busy_w;
  logic [MAC_NUM-1:0] mac_en;

  assign cfg_ok = (bus.kernel_size != '0) && (int'(bus.kernel_size) <= KMAX) &&
                  (bus.stride != '0) && (bus.ofmaps_width != '0) &&
                  (bus.ofmaps_height != '0) && (bus.ofmaps_channel != '0);

  always_comb begin
    if_state_d   = if_state_q;
    w_state_d    = w_state_q;
    k_d          = k_q;
    need_d       = need_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    stride_d     = stride_q;
    w_d          = w_q;
    h_d          = h_q;
    f_d          = f_q;
    ch_d         = ch_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    filter_cnt_d = filter_cnt_q;
    cfg_error_d  = 1'b0;
    filter_done  = 1'b0;

    // Weight FSM runs first so filter_done is visible to the ifmap FSM in the same cycle.
    case (w_state_q)
      W_IDLE:  if (if_state_q == COMPUTE) w_state_d = W_RESET;
      W_RESET: begin
        row_cnt_d    = '0;
        filter_cnt_d = '0;
        w_state_d    = W_ROW;
      end
      W_ROW: if (bus.weight_from_bram_valid) begin
        row_cnt_d = row_cnt_q + CNT_W'(1);
        if (row_cnt_q == k_q - CNT_W'(1)) w_state_d = W_LOAD;
      end
      W_LOAD: begin
        filter_cnt_d = filter_cnt_q + CH_W'(1);
        if (filter_cnt_q == f_q - CH_W'(1)) begin
          filter_done = 1'b1;
          w_state_d   = W_IDLE;
        end else begin
          row_cnt_d = '0;
          w_state_d = W_ROW;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    case (if_state_q)
      IDLE: if (bus.start) begin
        if (cfg_ok) begin
          k_d        = CNT_W'(bus.kernel_size);
          stride_d   = bus.stride;
          w_d        = bus.ofmaps_width;
          h_d        = bus.ofmaps_height;
          f_d        = bus.ofmaps_channel;
          ch_d       = bus.input_channel_size;
          need_d     = CNT_W'(bus.kernel_size);
          col_cnt_d  = '0;
          out_x_d    = '0;
          out_y_d    = '0;
          if_state_d = WAIT;
        end else begin
          cfg_error_d = 1'b1;
        end
      end
      WAIT: if (!bus.ifmaps_fifo_empty) if_state_d = LOAD;
      LOAD: begin
        col_cnt_d  = col_cnt_q + CNT_W'(1);
        if_state_d = (col_cnt_q + CNT_W'(1) == need_q) ? COMPUTE : WAIT;
      end
      COMPUTE: if (filter_done) begin
        col_cnt_d = '0;
        if (out_x_q == w_q - DIM_W'(1)) begin
          if (out_y_q == h_q - DIM_W'(1)) begin
            if_state_d = DONE;
          end else begin
            // New row: the whole KxK window must be refilled.
            out_x_d    = '0;
            out_y_d    = out_y_q + DIM_W'(1);
            need_d     = k_q;
            if_state_d = WAIT;
          end
        end else begin
          out_x_d    = out_x_q + DIM_W'(1);
          need_d     = CNT_W'(stride_q);
          if_state_d = WAIT;
        end
      end
      DONE: begin
        out_x_d    = '0;
        out_y_d    = '0;
        if_state_d = IDLE;
      end
      default: if_state_d = IDLE;
    endcase

    if (bus.abort) begin
      if_state_d   = IDLE;
      w_state_d    = W_IDLE;
      k_d          = '0;
      need_d       = '0;
      col_cnt_d    = '0;
      row_cnt_d    = '0;
      stride_d     = '0;
      w_d          = '0;
      h_d          = '0;
      f_d          = '0;
      ch_d         = '0;
      out_x_d      = '0;
      out_y_d      = '0;
      filter_cnt_d = '0;
      cfg_error_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_state_q   <= IDLE;
      w_state_q    <= W_IDLE;
      k_q          <= '0;
      need_q       <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      stride_q     <= '0;
      w_q          <= '0;
      h_q          <= '0;
      f_q          <= '0;
      ch_q         <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      filter_cnt_q <= '0;
      cfg_error_q  <= 1'b0;
    end else begin
      if_state_q   <= if_state_d;
      w_state_q    <= w_state_d;
      k_q          <= k_d;
      need_q       <= need_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      stride_q     <= stride_d;
      w_q          <= w_d;
      h_q          <= h_d;
      f_q          <= f_d;
      ch_q         <= ch_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      filter_cnt_q <= filter_cnt_d;
      cfg_error_q  <= cfg_error_d;
    end
  end

  assign busy_w = (if_state_q != IDLE);

  // Full-width compare so channel counts beyond MAC_NUM enable every lane.
  for (genvar gi = 0; gi < MAC_NUM; gi++) begin : g_lane
    assign mac_en[gi] = busy_w && (int'(ch_q) > gi);
  end

  assign bus.load_ifmaps         = (if_state_q == LOAD);
  assign bus.address_reset       = (w_state_q == W_RESET);
  assign bus.load_weight_preload = (w_state_q == W_ROW) && bus.weight_from_bram_valid;
  assign bus.bram_row_inc        = (w_state_q == W_ROW) && bus.weight_from_bram_valid;
  assign bus.load_weight         = (w_state_q == W_LOAD);
  assign bus.MAC_enable          = mac_en;
  assign bus.busy                = busy_w;
  assign bus.layer_finish        = (if_state_q == DONE);
  assign bus.cfg_error           = cfg_error_q;
  assign bus.out_x               = out_x_q;
  assign bus.out_y               = out_y_q;
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
- MAC_NUM, 256, number of MAC lanes.
- KMAX, 7, largest kernel size supported.
- CH_W, 12, channel-count width.
- DIM_W, 9, ofmap dimension width.
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle layer start (decoded compute instruction).
- abort  in  1  synchronous layer cancel.
- kernel_size  in  3  binary K, legal range 1..KMAX.
- stride  in  2  legal range 1..3.
- ofmaps_width  in  DIM_W  output width W.
- ofmaps_height  in  DIM_W  output height H.
- ofmaps_channel  in  CH_W  filter count F.
- input_channel_size  in  CH_W  active input channels.
- ifmaps_fifo_empty  in  1  ifmap FIFO empty.
- weight_from_bram_valid  in  1  BRAM weight row valid.
- load_ifmaps  out  1  pop and shift one ifmap column.
- address_reset  out  1  reset weight BRAM address.
- load_weight_preload  out  1  capture one weight row.
- bram_row_inc  out  1  advance weight BRAM address.
- load_weight  out  1  commit preloaded filter to MACs.
- MAC_enable  out  MAC_NUM  lane enables.
- busy  out  1  layer in progress.
- layer_finish  out  1  one-cycle done pulse.
- cfg_error  out  1  one-cycle illegal-config pulse.
- out_x, out_y  out  DIM_W each  current ofmap pixel.

Function
REQ-003 SHALL latch K, stride, W, H, F and input_channel_size on an accepted start; later changes to these inputs SHALL be ignored until IDLE.
REQ-004 SHALL reject start when K is 0 or greater than KMAX, stride is 0, or any of W, H, F is 0: cfg_error pulses for 1 cycle and the block stays IDLE.
REQ-005 In the ifmap FSM, start SHALL be ignored in every state other than IDLE.
REQ-006 ifmap FSM states SHALL be IDLE, WAIT, LOAD, COMPUTE, DONE.
REQ-007 IDLE -> WAIT on accepted start, with col_cnt=0, need=K, out_x=out_y=0.
REQ-008 WAIT -> LOAD when ifmaps_fifo_empty=0; otherwise stay in WAIT.
REQ-009 load_ifmaps SHALL be 1 exactly in LOAD; LOAD increments col_cnt, going to COMPUTE when col_cnt+1==need, else back to WAIT.
REQ-010 COMPUTE holds until filter_done (REQ-013). Then:
- out_x==W-1 and out_y==H-1: go to DONE.
- out_x==W-1: out_x=0, out_y+1, need=K (row refill), go to WAIT.
- otherwise: out_x+1, need=stride, go to WAIT.
- col_cnt is cleared in every case.
REQ-011 DONE SHALL assert layer_finish for 1 cycle, then go to IDLE; busy=1 in every state except IDLE.
REQ-012 weight FSM states SHALL be W_IDLE, W_RESET, W_ROW, W_LOAD; the cycle the ifmap FSM enters COMPUTE, W_IDLE -> W_RESET.
REQ-013 Weight FSM sequencing:
- W_RESET asserts address_reset for 1 cycle, clears row_cnt and filter_cnt, then goes to W_ROW.
- In W_ROW, each cycle with weight_from_bram_valid=1 asserts load_weight_preload and bram_row_inc together and increments row_cnt.
- When the K-th row is taken (row_cnt==K-1 and valid), go to W_LOAD.
- W_LOAD asserts load_weight for 1 cycle and increments filter_cnt.
- If filter_cnt==F-1, pulse the internal filter_done and go to W_IDLE; else clear row_cnt and go to W_ROW.
REQ-014 Minimum weight latency SHALL be K+1 cycles per filter and 2+F*(K+1) cycles from COMPUTE entry to filter_done.
REQ-015 load_weight_preload SHALL never assert without weight_from_bram_valid=1 in the same cycle; load_ifmaps SHALL never assert in a cycle where the FSM sampled the FIFO empty in the preceding WAIT.
REQ-016 MAC_enable[i] SHALL equal (i < input_channel_size) from the latched value; a value >= MAC_NUM enables all lanes, with no truncation; all lanes are 0 in IDLE.
REQ-017 abort SHALL take priority over all other transitions:
- Next cycle, both FSMs are in IDLE and all counters and outputs are 0.
- No layer_finish is issued.
- abort and start in the same cycle: abort wins and start is dropped.
REQ-018 Counter widths SHALL be DIM_W for out_x/out_y, CH_W for filter_cnt, and clog2(KMAX+1) for row_cnt/col_cnt; no counter wraps during a legal layer.

Reset
REQ-019 rst=1 at a clk edge SHALL force both FSMs to IDLE, all counters and latched configuration to 0, and every output to 0, including mid-layer; rst takes priority over abort and start.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- K=3, stride=1, W=H=2, F=2, FIFO never empty, valid always 1 -> 4 pixels; load_ifmaps count=3+1+3+1=8; load_weight count=8; one layer_finish; busy drops the cycle after it.
- K=1, stride=2, W=3, H=1, F=1 -> 1+2+2=5 load_ifmaps; each COMPUTE-to-filter_done is exactly 4 cycles.
- FIFO empty for 5 cycles in WAIT, and valid low for 3 cycles mid-filter -> no load_ifmaps or preload while stalled; the sequence then resumes with identical totals.
- start with K=0, then K=8, then F=0 -> three cfg_error pulses; busy stays 0.
- abort asserted in W_ROW with row_cnt=2 -> next cycle all outputs 0, no layer_finish; a fresh start then completes normally.
- input_channel_size=300 with MAC_NUM=256 -> all lanes enabled; size 5 -> lanes 0..4 enabled only; rst mid-layer -> all outputs 0 on the next cycle.
